// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory handshake bundle: req/gnt request phase, rvalid response phase.
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (read-only) and data (load/store)
// stages, with fetch-kill handling and a hung-memory timeout.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic [31:0]   if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_done,
  output logic          d_stall,
  mem_port_arbiter_if.master mem,
  output logic          timeout_err,
  output logic          busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // IDLE arbitrate | ISSUE hold req until gnt | WAIT await rvalid | RESP done next cycle
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          own_d;
  logic          killed;
  logic          if_done_q;
  logic          d_done_q;
  logic [CW-1:0] cnt;

  logic d_elig, if_elig, tmo, fetch_dead;

  // A requester whose done is showing still holds req that cycle; don't re-grant it.
  assign d_elig     = d_req & ~d_done_q;
  assign if_elig    = if_req & ~if_kill & ~if_done_q;
  assign tmo        = (cnt == CW'(TIMEOUT - 1));
  assign fetch_dead = ~own_d & (killed | if_kill);

  assign if_done  = if_done_q & ~if_kill;
  assign d_done   = d_done_q;
  assign if_stall = if_req & ~if_done & ~if_kill;
  assign d_stall  = d_req & ~d_done;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      own_d         <= 1'b0;
      killed        <= 1'b0;
      cnt           <= '0;
      if_done_q     <= 1'b0;
      d_done_q      <= 1'b0;
      timeout_err   <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= '0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (d_elig || if_elig) begin
            state       <= ISSUE;
            cnt         <= '0;
            killed      <= 1'b0;
            own_d       <= d_elig;
            mem.mem_req <= 1'b1;
            if (d_elig) begin
              mem.mem_we    <= d_we;
              mem.mem_be    <= d_be;
              mem.mem_addr  <= d_addr;
              mem.mem_wdata <= d_wdata;
            end else begin
              mem.mem_we    <= 1'b0;
              mem.mem_be    <= 4'hF;
              mem.mem_addr  <= if_addr;
              mem.mem_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (mem.mem_gnt) begin
            // Accepted even if killed this cycle: the response must still be drained.
            state       <= WAIT;
            mem.mem_req <= 1'b0;
            if (!own_d && if_kill) killed <= 1'b1;
          end else if (!own_d && if_kill) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            mem.mem_req <= 1'b0;
            state       <= RESP;
            if (own_d) d_rdata <= '0;
            else       if_rdata <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (!own_d && if_kill) killed <= 1'b1;
          if (mem.mem_rvalid) begin
            if (own_d) begin
              d_rdata <= mem.mem_rdata;
              state   <= RESP;
            end else if (fetch_dead) begin
              state <= IDLE;
            end else begin
              if_rdata <= mem.mem_rdata;
              state    <= RESP;
            end
          end else if (tmo) begin
            timeout_err <= 1'b1;
            if (own_d) begin
              d_rdata <= '0;
              state   <= RESP;
            end else if (fetch_dead) begin
              state <= IDLE;
            end else begin
              if_rdata <= '0;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          if (own_d)         d_done_q  <= 1'b1;
          else if (!if_kill) if_done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the memory cycle by cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, if_done, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_done, d_stall;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        timeout_err, busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter_if #(.AW(32)) mem ();

  mem_port_arbiter #(.AW(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem(mem),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b0;
    {if_req, if_kill, d_req, d_we} = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem.mem_gnt = 1'b0; mem.mem_rvalid = 1'b0; mem.mem_rdata = '0;
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    chk("rst_mem_req", mem.mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", {if_done, d_done, timeout_err}, 0);

    // 1: lone fetch, gnt with req, rvalid two cycles after gnt
    if_req = 1; if_addr = 32'h10;
    #1 chk("t1_stall_pre", if_stall, 1);
    tick();
    chk("t1_req", mem.mem_req, 1);
    chk("t1_addr", mem.mem_addr, 32'h10);
    chk("t1_we_be", {mem.mem_we, mem.mem_be}, 5'h0F);
    mem.mem_gnt = 1;
    tick();
    chk("t1_req_drop", mem.mem_req, 0);
    mem.mem_gnt = 0;
    tick();
    chk("t1_stall_wait", if_stall, 1);
    mem.mem_rvalid = 1; mem.mem_rdata = 32'h00500113;
    tick();
    mem.mem_rvalid = 0; mem.mem_rdata = '0;
    chk("t1_done_early", if_done, 0);
    tick();
    chk("t1_done", if_done, 1);
    chk("t1_rdata", if_rdata, 32'h00500113);
    chk("t1_stall_off", if_stall, 0);
    tick();
    chk("t1_done_once", if_done, 0);
    chk("t1_no_regrant", busy, 0);
    if_req = 0;
    tick();

    // 2: simultaneous fetch and store, data wins
    if_req = 1; if_addr = 32'h34;
    d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'hD; d_be = 4'hF;
    tick();
    chk("t2_addr", mem.mem_addr, 32'h60);
    chk("t2_we", mem.mem_we, 1);
    chk("t2_wdata", mem.mem_wdata, 32'hD);
    chk("t2_stalls", {if_stall, d_stall}, 2'b11);
    mem.mem_gnt = 1;
    tick();
    mem.mem_gnt = 0; mem.mem_rvalid = 1;
    tick();
    mem.mem_rvalid = 0;
    chk("t2_if_stall_mid", if_stall, 1);
    tick();
    chk("t2_d_done", d_done, 1);
    chk("t2_d_stall", d_stall, 0);
    chk("t2_if_stall", if_stall, 1);
    d_req = 0; d_we = 0;
    tick();
    chk("t2_f_req", mem.mem_req, 1);
    chk("t2_f_addr", mem.mem_addr, 32'h34);
    chk("t2_f_we", mem.mem_we, 0);
    chk("t2_d_done_once", d_done, 0);
    mem.mem_gnt = 1;
    tick();
    mem.mem_gnt = 0; mem.mem_rvalid = 1; mem.mem_rdata = 32'h12345678;
    tick();
    mem.mem_rvalid = 0;
    tick();
    chk("t2_if_done", if_done, 1);
    chk("t2_if_rdata", if_rdata, 32'h12345678);
    if_req = 0;
    tick();

    // 3: gnt held low three cycles; fields must not move
    d_req = 1; d_we = 1; d_addr = 32'h84; d_wdata = 32'hCAFE0001; d_be = 4'h3;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_hold_req", mem.mem_req, 1);
      chk("t3_hold_addr", mem.mem_addr, 32'h84);
      chk("t3_hold_wdata", mem.mem_wdata, 32'hCAFE0001);
      chk("t3_hold_be", mem.mem_be, 4'h3);
      if (k == 3) mem.mem_gnt = 1;
    end
    tick();
    chk("t3_req_drop", mem.mem_req, 0);
    mem.mem_gnt = 0; mem.mem_rvalid = 1; mem.mem_rdata = 32'h55AA55AA;
    tick();
    mem.mem_rvalid = 0;
    chk("t3_done_early", d_done, 0);
    tick();
    chk("t3_done", d_done, 1);
    d_req = 0; d_we = 0;
    tick();
    chk("t3_done_once", d_done, 0);
    chk("t3_idle", busy, 0);

    // 4a: kill in WAIT, response swallowed, then new fetch at 0x40
    if_req = 1; if_addr = 32'h20;
    tick();
    mem.mem_gnt = 1;
    tick();
    mem.mem_gnt = 0; if_kill = 1;
    #1 chk("t4_stall_kill", if_stall, 0);
    tick();
    if_kill = 0; if_addr = 32'h40;
    mem.mem_rvalid = 1; mem.mem_rdata = 32'hDEADBEEF;
    tick();
    mem.mem_rvalid = 0;
    chk("t4_no_done", if_done, 0);
    chk("t4_idle", busy, 0);
    tick();
    chk("t4_no_done2", if_done, 0);
    chk("t4_addr2", mem.mem_addr, 32'h40);
    chk("t4_req2", mem.mem_req, 1);
    mem.mem_gnt = 1;
    tick();
    mem.mem_gnt = 0; mem.mem_rvalid = 1; mem.mem_rdata = 32'h00000013;
    tick();
    mem.mem_rvalid = 0;
    tick();
    chk("t4_done2", if_done, 1);
    chk("t4_rdata2", if_rdata, 32'h00000013);
    if_req = 0;
    tick();

    // 4b: kill in ISSUE drops the request without a grant
    if_req = 1; if_addr = 32'h44;
    tick();
    chk("t4b_req", mem.mem_req, 1);
    if_kill = 1;
    tick();
    chk("t4b_req_drop", mem.mem_req, 0);
    chk("t4b_idle", busy, 0);
    if_kill = 0; if_req = 0;
    tick();
    chk("t4b_still_idle", busy, 0);

    // 5: load granted but never answered
    d_req = 1; d_we = 0; d_addr = 32'h90; d_be = 4'hF;
    tick();
    mem.mem_gnt = 1;
    tick();
    mem.mem_gnt = 0;
    seen = 1'b0;
    for (int k = 2; k <= 15; k++) begin
      tick();
      if (timeout_err) seen = 1'b1;
    end
    chk("t5_tmo_early", seen, 0);
    tick();
    chk("t5_tmo", timeout_err, 1);
    chk("t5_req", mem.mem_req, 0);
    tick();
    chk("t5_tmo_once", timeout_err, 0);
    chk("t5_done", d_done, 1);
    chk("t5_rdata", d_rdata, 32'h0);
    d_req = 0;
    tick();
    chk("t5_idle", busy, 0);

    // 6: async reset in the middle of WAIT
    if_req = 1; if_addr = 32'h50;
    tick();
    mem.mem_gnt = 1;
    tick();
    mem.mem_gnt = 0;
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_addr", mem.mem_addr, 32'h0);
    chk("t6_be", mem.mem_be, 4'h0);
    chk("t6_if_rdata", if_rdata, 32'h0);
    if_req = 0;
    @(posedge clk);
    #4 reset = 1'b1;
    tick();
    if_req = 1; if_addr = 32'h60;
    tick();
    chk("t6_f_addr", mem.mem_addr, 32'h60);
    mem.mem_gnt = 1;
    tick();
    mem.mem_gnt = 0; mem.mem_rvalid = 1; mem.mem_rdata = 32'h0000ABCD;
    tick();
    mem.mem_rvalid = 0;
    tick();
    chk("t6_done", if_done, 1);
    chk("t6_rdata", if_rdata, 32'h0000ABCD);
    if_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
